// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx (and its sibling uart_tx).
//   uart_rx_state_t : receiver FSM state encoding
//   PAR_NONE/EVEN/ODD : parity_mode encodings (2'b11 behaves as none)
//   clks_per_bit()  : truncating system clocks per serial bit
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } uart_rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for a single asynchronous bit.
//   clk, rst   : system clock, synchronous active-high reset
//   rst_val_i  : value every flop takes during reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (N clocks of latency), N >= 2
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{rst_val_i}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detection with mid-bit recheck, centre sampling of
// data / optional parity / stop bits, one-entry output buffer.
//   clk, rst          : system clock, synchronous active-high reset
//   rx                : asynchronous serial input, idle high
//   parity_mode       : 00 none, 01 even, 10 odd, 11 none (latched on start)
//   rx_data/rx_valid/rx_ready : output word handshake; a transfer happens on
//                       a rising clk edge where rx_valid && rx_ready. rx_data
//                       and the flags are stable while rx_valid is high, and
//                       rx_valid only drops after a transfer.
//   frame_err, parity_err : status of the presented word (qualified by rx_valid)
//   overrun           : 1-cycle pulse when a completed frame is dropped
//   busy              : high whenever the FSM is not in IDLE
//   dbg_state_o       : current FSM state
// Optional feature macro: UART_RX_PARITY_EN (parity state and checking).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1_000_000,
  parameter int BAUD_RATE = 10_000,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output uart_rx_state_t       dbg_state_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
  // The counter counts down to zero, so a load of K-1 gives a K-clock interval.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  logic rx_s;

  uart_sync #(.N(2)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rst_val_i (1'b1),
    .d_i       (rx),
    .q_o       (rx_s)
  );

  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   ferr_q, ferr_d;
  logic                   last_stop_q, last_stop_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   tick;

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_mode_q, par_mode_d;
  logic       perr_q, perr_d;
  logic       parity_err_q, parity_err_d;
  logic       par_on;
  assign par_on = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    ferr_d      = ferr_q;
    last_stop_d = last_stop_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mode_d   = par_mode_q;
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
`endif

    // Handshake drains the buffer; a DONE load below overrides this.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
`ifdef UART_RX_PARITY_EN
          par_mode_d = parity_mode;
`endif
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = ST_IDLE;  // glitch shorter than half a bit
        end else begin
          state_d = ST_DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // LSB arrives first, so shift right and insert at the top.
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST_DATA) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_on ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Even mode wants XOR(data, bit) == 0, odd mode wants 1.
          perr_d  = (^shreg_q ^ rx_s) != (par_mode_q == PAR_ODD);
          cnt_d   = CNT_FULL;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
          last_stop_d = rx_s;
          cnt_d       = CNT_FULL;
          if (idx_q == IDX_LAST_STOP) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!valid_q || rx_ready) begin
          data_d      = shreg_q;
          frame_err_d = ferr_q;
          valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err_d = perr_q;
`endif
        end else begin
          overrun_d = 1'b1;
        end
        // A low final stop sample may be a break; wait for the line to rise.
        state_d = last_stop_q ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      ferr_q      <= 1'b0;
      last_stop_q <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mode_q   <= PAR_NONE;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      ferr_q      <= ferr_d;
      last_stop_q <= last_stop_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_mode_q   <= par_mode_d;
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus a randomized frame stream, each
// received word compared against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 10_000;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 rx;
  logic [1:0]           parity_mode;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;
  uart_rx_state_t       dbg_state;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .parity_mode (parity_mode),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- monitor ----------------
  // Samples 1 time unit before each rising edge: outputs settled since the
  // previous edge, inputs settled since the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DATA_BITS+1:0] obs_q[$];
  logic [DATA_BITS+1:0] exp_q[$];
  int   valid_cycles   = 0;
  int   overrun_pulses = 0;
  int   valid_rise_cyc = 0;
  logic valid_prev     = 1'b0;

  always @(negedge clk) begin
    #4;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) obs_q.push_back({parity_err, frame_err, rx_data});
    if (rx_valid === 1'b1) valid_cycles++;
    if (overrun === 1'b1) overrun_pulses++;
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit parity_used(input logic [1:0] mode);
    return PAR_EN && (mode == 2'b01 || mode == 2'b10);
  endfunction

  function automatic logic [DATA_BITS+1:0] model(input logic [DATA_BITS-1:0] d,
                                                 input logic [1:0] mode,
                                                 input logic pbit,
                                                 input logic [1:0] stops);
    logic fe;
    logic pe;
    int   ones;
    fe = 1'b0;
    pe = 1'b0;
    for (int s = 0; s < STOP_BITS; s++) if (stops[s] == 1'b0) fe = 1'b1;
    if (parity_used(mode)) begin
      ones = $countones(d) + int'(pbit);
      pe = (mode == 2'b01) ? (ones % 2 != 0) : (ones % 2 == 0);
    end
    return {pe, fe, d};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic [1:0] mode,
                            input logic pbit, input logic [1:0] stops, output int c0);
    parity_mode = mode;
    c0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    if (parity_used(mode)) drive_bit(pbit);
    for (int s = 0; s < STOP_BITS; s++) drive_bit(stops[s]);
    rx = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0;
    int gap;
    logic [DATA_BITS-1:0] d;
    logic [1:0] mode;
    logic [1:0] st;
    logic pb;
    logic [DATA_BITS-1:0] d3c;

    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; parity_mode = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_flags", {frame_err, parity_err, overrun}, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 0xAA, ready high: one-cycle valid, clean flags, exact latency.
    // Counted in rising edges after the falling drive: the first edge captures
    // rx, the start is confirmed 2+HALF clocks after that capture, the last
    // stop centre is 9 bit times later, and rx_valid rises one clock after it.
    valid_cycles = 0;
    send_frame(8'hAA, 2'b00, 1'b0, 2'b11, c0);
    exp_q.push_back(model(8'hAA, 2'b00, 1'b0, 2'b11));
    repeat (2 * CPB) @(negedge clk);
    check("aa_valid_cycles", valid_cycles, 1);
    check("aa_latency", valid_rise_cyc - c0, 1 + (2 + HALF) + (DATA_BITS + STOP_BITS) * CPB + 1);
    score("aa");

    // 20-clock glitch: false start, no word, busy released.
    valid_cycles = 0;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_valid", valid_cycles, 0);
    score("glitch");

    // 0x55 with a low stop bit, then a long break.
    send_frame(8'h55, 2'b00, 1'b0, 2'b00, c0);
    rx = 1'b0;
    exp_q.push_back(model(8'h55, 2'b00, 1'b0, 2'b00));
    repeat (1000) @(negedge clk);
    check("break_busy", busy, 1);
    repeat (1000) @(negedge clk);
    check("break_one_word", obs_q.size(), 1);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("break_idle", busy, 0);
    score("break");

    // 0x03 in even mode with parity bit 1 (error) then 0 (clean).
    send_frame(8'h03, 2'b01, 1'b1, 2'b11, c0);
    exp_q.push_back(model(8'h03, 2'b01, 1'b1, 2'b11));
    repeat (CPB) @(negedge clk);
    send_frame(8'h03, 2'b01, 1'b0, 2'b11, c0);
    exp_q.push_back(model(8'h03, 2'b01, 1'b0, 2'b11));
    repeat (2 * CPB) @(negedge clk);
    score("parity");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    overrun_pulses = 0;
    send_frame(8'h11, 2'b00, 1'b0, 2'b11, c0);
    repeat (20) @(negedge clk);
    send_frame(8'h22, 2'b00, 1'b0, 2'b11, c0);
    repeat (2 * CPB) @(negedge clk);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_pulses", overrun_pulses, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_valid_cleared", rx_valid, 0);
    exp_q.push_back(model(8'h11, 2'b00, 1'b0, 2'b11));
    score("ovr");
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Reset in the middle of the data bits of 0x3C.
    d3c = 8'h3C;
    parity_mode = 2'b00;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d3c[i]);
    rx = d3c[3];
    repeat (HALF) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_flags", {frame_err, parity_err, overrun}, 0);
    check("midrst_busy", busy, 0);
    repeat (3 * CPB) @(negedge clk);
    check("midrst_no_word", obs_q.size(), 0);
    send_frame(8'h5A, 2'b00, 1'b0, 2'b11, c0);
    exp_q.push_back(model(8'h5A, 2'b00, 1'b0, 2'b11));
    repeat (2 * CPB) @(negedge clk);
    score("after_rst");

    // Random stream: random data, parity mode, parity bit, stop bits, gaps.
    overrun_pulses = 0;
    for (int k = 0; k < 20; k++) begin
      d    = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
      mode = 2'($urandom_range(0, 3));
      pb   = 1'($urandom_range(0, 1));
      st   = 2'b11;
      for (int s = 0; s < STOP_BITS; s++) if ($urandom_range(0, 3) == 0) st[s] = 1'b0;
      exp_q.push_back(model(d, mode, pb, st));
      send_frame(d, mode, pb, st, c0);
      gap = (st[STOP_BITS-1] == 1'b0) ? CPB + int'($urandom_range(0, 30)) : int'($urandom_range(0, 30));
      repeat (gap) @(negedge clk);
    end
    repeat (3 * CPB) @(negedge clk);
    check("rand_no_overrun", overrun_pulses, 0);
    score("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of `uart_tx`, sharing its parameter set and frame format. It synchronizes the asynchronous `rx` line and detects start bits with a mid-bit glitch check. It samples data, optional parity and stop bits at bit centres, then presents each byte on a valid/ready output handshake with framing, parity and overrun status. It sits between the pad-side serial input and the byte-stream consumer.

## Interface
- `CLK_FREQ`, 1_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 10_000: serial bit rate in baud.
- `DATA_BITS`, 8: data bits per frame, 5..9, sent LSB first.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none. Sampled in IDLE on start detect.
- `rx_data` out DATA_BITS: received word, held while `rx_valid`=1.
- `rx_valid` out 1: word available.
- `rx_ready` in 1: consumer accepts; transfer completes when `rx_valid && rx_ready`.
- `frame_err` out 1: stop-bit error for the presented word, qualified by `rx_valid`.
- `parity_err` out 1: parity mismatch for the presented word, qualified by `rx_valid`.
- `overrun` out 1: one-cycle pulse when a frame completes while `rx_valid` is still 1.
- `busy` out 1: high in every state except IDLE.

## Operation
- `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (truncating). `HALF_BIT = CLKS_PER_BIT/2`. Bit counter width is `$clog2(CLKS_PER_BIT)`.
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- States:
  - IDLE: on `rx_s`=0, load the baud counter and go to START.
  - START: after HALF_BIT clocks, resample `rx_s`. If 0, go to DATA. If 1, this is a false start; return to IDLE with no output.
  - DATA: sample `rx_s` every CLKS_PER_BIT clocks into a shift register, LSB first, DATA_BITS times. Then go to PARITY if parity is enabled, else to STOP.
  - PARITY: sample one bit. Even mode expects XOR(data)^bit = 0. Odd mode expects it to be 1.
  - STOP: sample STOP_BITS bits. Any 0 sets the frame error.
  - DONE: load `rx_data` and the flags, then go to IDLE. If the last stop sample was 0, go to WAIT_IDLE instead.
  - WAIT_IDLE: hold until `rx_s`=1, then go to IDLE. This absorbs break conditions without emitting repeated frames.
- Output buffer is one entry. If `rx_valid`=0 in DONE, the buffer loads and `rx_valid` is set. If `rx_valid`=1, the new frame is dropped, the old word and flags are kept, and `overrun` pulses.
- `rx_valid` clears on the cycle after handshake. A DONE load in that same cycle takes priority: the buffer refills, `rx_valid` stays 1, and there is no overrun.
- Frames with errors are still delivered, with the flags set.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0. State is IDLE and the synchronizer flops are 1.
- Reset mid-frame aborts immediately. No partial word is emitted.
- Synchronizer latency is 2 clocks. The start bit is confirmed 2+HALF_BIT clocks after the `rx` falling edge.
- Each subsequent sample is exactly CLKS_PER_BIT clocks after the previous one.
- `rx_valid` rises 1 clock after the centre sample of the last stop bit.
- `busy` falls with the return to IDLE, about half a bit before the end of the line stop bit, so back-to-back frames are accepted.

## Configuration
- `UART_RX_PARITY_EN` defined: parity logic and the PARITY state are compiled in, and `parity_mode` behaves as above.
- `UART_RX_PARITY_EN` undefined: `parity_mode` is ignored, the PARITY state is absent, `parity_err` is tied 0, and a frame is always start + DATA_BITS + STOP_BITS.

## Structure
- `uart_pkg`: state enum `uart_rx_state_t`, parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`, and a `clks_per_bit` function shared with `uart_tx`.
- Sub-module `uart_sync`: a parameterizable N-flop synchronizer with a reset value input, instanced once for `rx`.

## Test plan
At CLK_FREQ=1_000_000 and BAUD_RATE=10_000 (100 clocks/bit), a bench must cover:
- Drive 0xAA (line 0,0,1,0,1,0,1,0,1,1), `rx_ready`=1 → `rx_valid` for 1 cycle with `rx_data`=0xAA and both error flags 0.
- Pulse `rx` low for 20 clocks → no `rx_valid`, `busy` returns to 0 within ~55 clocks.
- Send 0x55 with stop bit 0, then hold `rx` low for 2000 clocks → one word 0x55 with `frame_err`=1, no further words until `rx` returns high.
- With `UART_RX_PARITY_EN` and `parity_mode`=01, send 0x03 with parity bit 1 → `parity_err`=1. Send it with parity bit 0 → `parity_err`=0.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses once. After a handshake, `rx_valid`=0.
- Assert `rst` for 1 cycle mid-data of 0x3C → no output, all outputs at reset values. The next frame 0x5A is received correctly.
